// File: rtl/rbus_xbar_pkt_nxm.sv
// Packet-switched N x M rbus crossbar: per-input word FIFOs, per-output arbiters locked sof..last word.
// Build macro RBUS_XBAR_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module rbus_xbar_pkt_nxm #(
  parameter int N        = 2,
  parameter int M        = 4,
  parameter int DEPTH    = 32,
  parameter int DEST_LSB = 64,
  parameter int LEN_LSB  = 56,
  parameter int CLS_BIT  = 60,
  parameter int MAXLEN   = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          i_stb,
  input  logic [N-1:0]          i_sof,
  input  logic [N-1:0][71:0]    i_data,
  output logic [N-1:0][1:0]     i_rdy,
  output logic [N-1:0][1:0]     i_rdyE,
  output logic [M-1:0]          o_stb,
  output logic [M-1:0]          o_sof,
  output logic [M-1:0][71:0]    o_data,
  input  logic [M-1:0][1:0]     o_rdy,
  input  logic [M-1:0][1:0]     o_rdyE,
  output logic                  ff_err
);
  localparam int NW  = (N > 1) ? $clog2(N) : 1;
  localparam int AW  = $clog2(DEPTH);
  // dest is decoded over 4 bits so out-of-range destinations are seen rather than aliased
  localparam int DFW = 4;

  // state   | meaning
  // S_IDLE  | arbitrating among heads that target this output
  // S_GRANT | locked to r_win, r_cnt payload words still to forward
  typedef enum logic {S_IDLE, S_GRANT} st_t;

  logic [72:0]   r_mem  [N][DEPTH];
  logic [AW:0]   r_wp   [N];
  logic [AW:0]   r_rp   [N];
  logic [3:0]    r_wrem [N];
  logic [3:0]    r_dcnt [N];
  logic [N-1:0]  r_disc;
  st_t           r_st   [M];
  logic [NW-1:0] r_win  [M];
  logic [3:0]    r_cnt  [M];
`ifndef RBUS_XBAR_FIXED_PRIO_EN
  logic [NW-1:0] r_ptr  [M];
`endif

  logic [AW:0]     w_cnt   [N];
  logic [72:0]     w_head  [N];
  logic [DFW-1:0]  w_dest  [N];
  logic [3:0]      w_hlen  [N];
  logic [N-1:0]    w_empty, w_full, w_hsof, w_cls, w_bad, w_wsof, w_busy, w_idle_head;
  logic [N-1:0]    w_pop, w_dstart;
  logic [M-1:0]    w_gnt_v, w_spop;
  logic [NW-1:0]   w_gnt_n [M];
  logic            w_err;
  logic            w_unused_rdye;

  assign w_unused_rdye = ^o_rdyE;

  always_comb begin
    for (int n = 0; n < N; n++) begin
      w_cnt[n]   = r_wp[n] - r_rp[n];
      w_empty[n] = (w_cnt[n] == '0);
      w_full[n]  = (int'(w_cnt[n]) == DEPTH);
      w_head[n]  = r_mem[n][r_rp[n][AW-1:0]];
      w_hsof[n]  = w_head[n][72];
      w_dest[n]  = w_head[n][DEST_LSB +: DFW];
      w_hlen[n]  = w_head[n][LEN_LSB +: 4];
      w_cls[n]   = w_head[n][CLS_BIT];
      w_bad[n]   = (int'(w_dest[n]) >= M) || (int'(w_hlen[n]) > MAXLEN);
      w_wsof[n]  = i_sof[n] && (r_wrem[n] == '0);
      w_busy[n]  = r_disc[n];
      for (int m = 0; m < M; m++)
        if (r_st[m] == S_GRANT && int'(r_win[m]) == n) w_busy[n] = 1'b1;
      w_idle_head[n] = !w_empty[n] && !w_busy[n];
    end
  end

  always_comb begin
    int idx;
    idx = 0;
    for (int m = 0; m < M; m++) begin
      w_gnt_v[m] = 1'b0;
      w_gnt_n[m] = '0;
      w_spop[m]  = (r_st[m] == S_GRANT) && !w_empty[r_win[m]];
      if (r_st[m] == S_IDLE) begin
        for (int k = 0; k < N; k++) begin
`ifdef RBUS_XBAR_FIXED_PRIO_EN
          idx = k;
`else
          idx = (int'(r_ptr[m]) + k) % N;
`endif
          if (!w_gnt_v[m] && w_idle_head[idx] && w_hsof[idx] && !w_bad[idx] &&
              int'(w_dest[idx]) == m && o_rdy[m][w_cls[idx]]) begin
            w_gnt_v[m] = 1'b1;
            w_gnt_n[m] = NW'(idx);
          end
        end
      end
    end
  end

  // Bad headers and stray non-sof heads are drained so the FIFO never wedges.
  always_comb begin
    w_pop    = '0;
    w_dstart = '0;
    w_err    = 1'b0;
    for (int n = 0; n < N; n++) begin
      w_dstart[n] = w_idle_head[n] && w_hsof[n] && w_bad[n];
      if ((r_disc[n] && !w_empty[n]) || (w_idle_head[n] && (!w_hsof[n] || w_bad[n])))
        w_pop[n] = 1'b1;
      if (w_dstart[n] || (i_stb[n] && (w_full[n] || (i_sof[n] && r_wrem[n] != '0))))
        w_err = 1'b1;
    end
    for (int m = 0; m < M; m++) begin
      if (w_gnt_v[m]) w_pop[w_gnt_n[m]] = 1'b1;
      if (w_spop[m])  w_pop[r_win[m]]   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int n = 0; n < N; n++)
      if (i_stb[n] && !w_full[n]) r_mem[n][r_wp[n][AW-1:0]] <= {w_wsof[n], i_data[n]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int n = 0; n < N; n++) begin
        r_wp[n]   <= '0;
        r_rp[n]   <= '0;
        r_wrem[n] <= '0;
        r_dcnt[n] <= '0;
      end
      r_disc <= '0;
      i_rdy  <= '0;
      i_rdyE <= '0;
      ff_err <= 1'b0;
    end else begin
      ff_err <= ff_err | w_err;
      for (int n = 0; n < N; n++) begin
        if (i_stb[n] && !w_full[n]) begin
          r_wp[n] <= r_wp[n] + (AW+1)'(1);
          if (w_wsof[n])              r_wrem[n] <= i_data[n][LEN_LSB +: 4];
          else if (r_wrem[n] != '0)   r_wrem[n] <= r_wrem[n] - 4'd1;
        end
        if (w_pop[n]) r_rp[n] <= r_rp[n] + (AW+1)'(1);
        if (w_dstart[n]) begin
          r_disc[n] <= (w_hlen[n] != '0);
          r_dcnt[n] <= w_hlen[n];
        end else if (r_disc[n] && !w_empty[n]) begin
          r_dcnt[n] <= r_dcnt[n] - 4'd1;
          if (r_dcnt[n] == 4'd1) r_disc[n] <= 1'b0;
        end
        i_rdy[n]  <= {2{int'(w_cnt[n]) <= DEPTH - MAXLEN - 1}};
        i_rdyE[n] <= {2{w_empty[n]}};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int m = 0; m < M; m++) begin
        r_st[m]  <= S_IDLE;
        r_win[m] <= '0;
        r_cnt[m] <= '0;
`ifndef RBUS_XBAR_FIXED_PRIO_EN
        r_ptr[m] <= '0;
`endif
      end
      o_stb  <= '0;
      o_sof  <= '0;
      o_data <= '0;
    end else begin
      for (int m = 0; m < M; m++) begin
        o_sof[m] <= 1'b0;
        o_stb[m] <= 1'b0;
        if (r_st[m] == S_IDLE) begin
          if (w_gnt_v[m]) begin
            r_win[m]  <= w_gnt_n[m];
            r_cnt[m]  <= w_hlen[w_gnt_n[m]];
            r_st[m]   <= (w_hlen[w_gnt_n[m]] != '0) ? S_GRANT : S_IDLE;
            o_stb[m]  <= 1'b1;
            o_sof[m]  <= 1'b1;
            o_data[m] <= w_head[w_gnt_n[m]][71:0];
`ifndef RBUS_XBAR_FIXED_PRIO_EN
            r_ptr[m]  <= (int'(w_gnt_n[m]) == N - 1) ? '0 : w_gnt_n[m] + NW'(1);
`endif
          end
        end else if (w_spop[m]) begin
          o_stb[m]  <= 1'b1;
          o_data[m] <= w_head[r_win[m]][71:0];
          r_cnt[m]  <= r_cnt[m] - 4'd1;
          if (r_cnt[m] == 4'd1) r_st[m] <= S_IDLE;
        end
      end
    end
  end
endmodule
